matrix_mult_3x3: RTL and testbench



---
 rtl/matrix_mult_3x3.sv | 129 ++++++++++++
 tb/tb_matrix_mult_3x3.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_3x3.sv
// Sequential 3x3 matrix multiply C = A x B, one MAC per clock; done 27 cycles after an accepted start.
// No backpressure: start is ignored unless IDLE. MATMUL_SIGNED_EN selects two's-complement operands.
module matrix_mult_3x3 #(
   parameter int DW = 8,
   parameter int N  = 3,
   parameter int RW = 2*DW+2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N*N*DW-1:0] a_data,
   input  logic [N*N*DW-1:0] b_data,
   output logic              busy,
   output logic              done,
   output logic              c_valid,
   output logic [3:0]        c_index,
   output logic [RW-1:0]     c_elem,
   output logic [N*N*RW-1:0] c_data
);

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t              state_q;
   logic [N*N*DW-1:0]   a_q, b_q;
   logic [1:0]          i_q, j_q, k_q;
   logic [RW-1:0]       acc_q, acc_d;
   logic                busy_q, done_q, c_valid_q;
   logic [3:0]          c_index_q;
   logic [RW-1:0]       c_elem_q;
   logic [N*N*RW-1:0]   c_data_q;

   logic [3:0]          a_idx, b_idx, c_idx;
   logic [DW-1:0]       a_el, b_el;
   logic [2*DW-1:0]     prod;
   logic [RW-1:0]       prod_ext;
   logic                k_last, last_mac;

   always_comb begin
      a_idx    = 4'(i_q) * 4'd3 + 4'(k_q);
      b_idx    = 4'(k_q) * 4'd3 + 4'(j_q);
      c_idx    = 4'(i_q) * 4'd3 + 4'(j_q);
      a_el     = a_q[a_idx*DW +: DW];
      b_el     = b_q[b_idx*DW +: DW];
`ifdef MATMUL_SIGNED_EN
      // Low 2*DW bits of the product of sign-extended operands is the signed product.
      prod     = {{DW{a_el[DW-1]}}, a_el} * {{DW{b_el[DW-1]}}, b_el};
      prod_ext = {{(RW-2*DW){prod[2*DW-1]}}, prod};
`else
      prod     = {{DW{1'b0}}, a_el} * {{DW{1'b0}}, b_el};
      prod_ext = {{(RW-2*DW){1'b0}}, prod};
`endif
      acc_d    = ((k_q == 2'd0) ? '0 : acc_q) + prod_ext;
      k_last   = (k_q == 2'd2);
      last_mac = (i_q == 2'd2) && (j_q == 2'd2) && k_last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         i_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         c_valid_q <= 1'b0;
         c_index_q <= '0;
         c_elem_q  <= '0;
         c_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               c_valid_q <= 1'b0;
               done_q    <= 1'b0;
               if (start) begin
                  a_q      <= a_data;
                  b_q      <= b_data;
                  c_data_q <= '0;
                  i_q      <= '0;
                  j_q      <= '0;
                  k_q      <= '0;
                  acc_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= COMPUTE;
               end
            end
            COMPUTE: begin
               acc_q     <= acc_d;
               c_valid_q <= k_last;
               if (k_last) begin
                  c_data_q[c_idx*RW +: RW] <= acc_d;
                  c_elem_q  <= acc_d;
                  c_index_q <= c_idx;
                  k_q       <= '0;
                  if (j_q == 2'd2) begin
                     j_q <= '0;
                     i_q <= (i_q == 2'd2) ? 2'd0 : i_q + 2'd1;
                  end else begin
                     j_q <= j_q + 2'd1;
                  end
               end else begin
                  k_q <= k_q + 2'd1;
               end
               if (last_mac) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               c_valid_q <= 1'b0;
               done_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign c_valid = c_valid_q;
   assign c_index = c_index_q;
   assign c_elem  = c_elem_q;
   assign c_data  = c_data_q;

endmodule

// File: tb/tb_matrix_mult_3x3.sv
// Scoreboard bench for matrix_mult_3x3: driver pushes reference results, negedge monitor pops and compares.
module tb_matrix_mult_3x3;
   localparam int DW = 8;
   localparam int RW = 18;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [71:0]  a_data, b_data;
   logic         busy, done, c_valid;
   logic [3:0]   c_index;
   logic [17:0]  c_elem;
   logic [161:0] c_data;

   always #5 clk = ~clk;

   matrix_mult_3x3 #(.DW(DW), .N(3), .RW(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .a_data(a_data), .b_data(b_data),
      .busy(busy), .done(done), .c_valid(c_valid), .c_index(c_index),
      .c_elem(c_elem), .c_data(c_data)
   );

   typedef struct { int idx; logic [17:0] val; int cyc; } elem_t;
   typedef struct { logic [161:0] c; int cyc; int s0; } done_t;

   elem_t elem_q[$];
   done_t done_q[$];
   int    ncyc   = 0;
   int    checks = 0;
   int    errors = 0;

   function automatic int el(input logic [71:0] m, input int r, input int c);
      logic [7:0] v;
      v = m[(3*r+c)*8 +: 8];
`ifdef MATMUL_SIGNED_EN
      return int'($signed(v));
`else
      return int'(v);
`endif
   endfunction

   function automatic logic [161:0] ref_mul(input logic [71:0] a, input logic [71:0] b);
      logic [161:0] res;
      int s;
      res = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            s = 0;
            for (int k = 0; k < 3; k++) s += el(a, r, k) * el(b, k, c);
            res[(3*r+c)*18 +: 18] = s[17:0];
         end
      return res;
   endfunction

   function automatic logic [71:0] pack9(input int v[9]);
      logic [71:0] m;
      for (int n = 0; n < 9; n++) m[n*8 +: 8] = 8'(v[n]);
      return m;
   endfunction

   task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   // Monitor: one pass per negedge, ncyc counts negedges.
   initial begin
      elem_t e;
      done_t d;
      logic  exp_busy;
      forever begin
         @(negedge clk);
         ncyc = ncyc + 1;
         exp_busy = (done_q.size() > 0) && (ncyc >= done_q[0].s0) && (ncyc < done_q[0].cyc);
         chk("busy", busy, exp_busy);
         if (c_valid === 1'b1) begin
            if (elem_q.size() == 0) chk("c_valid_unexpected", 1, 0);
            else begin
               e = elem_q.pop_front();
               chk("c_index", c_index, e.idx);
               chk("c_elem", c_elem, e.val);
               chk("c_valid_cycle", ncyc, e.cyc);
            end
         end
         if (done === 1'b1) begin
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               d = done_q.pop_front();
               chk("c_data", c_data, d.c);
               chk("done_cycle", ncyc, d.cyc);
            end
         end
      end
   end

   task automatic goto_cyc(input int t);
      while (ncyc < t) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Drive start for 'hold' edges; the last of them is the accepting edge E0.
   task automatic issue(input logic [71:0] a, input logic [71:0] b, input int hold, output int s0);
      logic [161:0] r;
      r  = ref_mul(a, b);
      s0 = ncyc + hold;
      for (int n = 0; n < 9; n++) elem_q.push_back('{n, r[n*18 +: 18], s0 + 3*n + 3});
      done_q.push_back('{r, s0 + 27, s0});
      a_data = a;
      b_data = b;
      start  = 1'b1;
      repeat (hold) begin
         @(negedge clk);
         #1;
      end
      start  = 1'b0;
      a_data = {8'($urandom), 32'($urandom), 32'($urandom)};
      b_data = {8'($urandom), 32'($urandom), 32'($urandom)};
   endtask

   function automatic logic [71:0] rnd72();
      return {8'($urandom), 32'($urandom), 32'($urandom)};
   endfunction

   initial begin
      int s0, s1, gap;
      int v[9];
      logic [71:0] ma, mb;

      rst = 1'b1; start = 1'b0; a_data = '0; b_data = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_c_valid", c_valid, 0);
      chk("rst_c_index", c_index, 0);
      chk("rst_c_elem", c_elem, 0);
      chk("rst_c_data", c_data, 0);
      rst = 1'b0;
      @(negedge clk); #1;

      v = '{1, 0, 0, 0, 1, 0, 0, 0, 1}; ma = pack9(v);
      v = '{1, 2, 3, 4, 5, 6, 7, 8, 9}; mb = pack9(v);
      issue(ma, mb, 1, s0);
      goto_cyc(s0 + 28);

      issue({9{8'hFF}}, {9{8'hFF}}, 1, s0);
      goto_cyc(s0 + 28);

      issue(mb, mb, 1, s0);
      goto_cyc(s0 + 28);

      // Start while busy is ignored; start held through the DONE cycle is taken one edge later.
      issue(rnd72(), rnd72(), 1, s0);
      goto_cyc(s0 + 9);
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      chk("busy_after_ignored_start", busy, 1);
      goto_cyc(s0 + 27);
      issue(mb, ma, 2, s1);
      chk("backtoback_spacing", s1 - s0, 29);
      goto_cyc(s1 + 28);

      // Reset at edge E12 of an operation in flight.
      issue(rnd72(), rnd72(), 1, s0);
      goto_cyc(s0 + 11);
      rst = 1'b1;
      elem_q.delete();
      done_q.delete();
      @(negedge clk); #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_c_valid", c_valid, 0);
      chk("midrst_c_data", c_data, 0);
      rst = 1'b0;
      @(negedge clk); #1;
      issue(mb, mb, 1, s0);
      goto_cyc(s0 + 28);

`ifdef MATMUL_SIGNED_EN
      issue({9{8'hFF}}, {9{8'h80}}, 1, s0);
      goto_cyc(s0 + 28);
      issue({9{8'h80}}, {9{8'h7F}}, 1, s0);
      goto_cyc(s0 + 28);
`endif

      issue(rnd72(), rnd72(), 1, s0);
      for (int t = 0; t < 12; t++) begin
         gap = $urandom_range(0, 3);
         goto_cyc(s0 + 27 + gap);
         issue(rnd72(), rnd72(), (gap == 0) ? 2 : 1, s0);
      end
      goto_cyc(s0 + 32);

      chk("scoreboard_drained", 32'(elem_q.size() + done_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
